// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit-side frame serializer and the
// receive-side 3-byte shift register.
//   tx_state_t         : per-character serializer state
//   UART_DATA_BITS     : data bits per 8N1 character
//   FRAME_BYTES        : bytes per frame (matches the receive shift register)
//   calc_clks_per_bit  : clock cycles per serial bit from clock and baud rate
package uart_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int FRAME_BYTES    = 3;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-character 8N1 serializer with a valid/ready handshake.
//   clk, rst_n : clock, synchronous active-low reset
//   valid      : data holds a character to send
//   data       : character, sent LSB first
//   ready      : character accepted on this edge when valid is also high;
//                also high in the last cycle of a stop bit so the next start
//                bit follows with no idle gap
//   tx         : serial line, registered, idle high
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx
);

    localparam int              CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      BIT_LAST  = 3'(UART_DATA_BITS - 1);

    tx_state_t     state_q, state_d;
    logic [CW-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          bit_end;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

    assign bit_end = (baud_cnt_q == BAUD_LAST);
    assign ready   = (state_q == IDLE) || ((state_q == STOP) && bit_end);
    assign tx      = tx_q;

    // NOTE: every output of this block gets a default first; a path that
    // skipped one would infer a latch.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = bit_end ? '0 : baud_cnt_q + CW'(1);
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;

        unique case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
                tx_d       = 1'b1;
                if (valid) begin
                    state_d = START;
                    shift_d = data;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d   = STOP;
                        bit_cnt_d = '0;
                        tx_d      = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    // A character offered here starts on the very next edge,
                    // keeping characters back-to-back.
                    if (valid) begin
                        state_d = START;
                        shift_d = data;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/uart_frame_tx.sv
// Serializes a 3-byte frame as three back-to-back 8N1 characters, byte 2
// first, so a receiving 3-byte shift register ends with each byte at the
// same index it has here.
//   clk, rst_n   : clock, synchronous active-low reset
//   start        : request a frame; honoured only while busy is low
//   byte_in0..2  : frame bytes, captured on the accept edge
//   tx           : serial line, idle high
//   busy         : frame in flight
//   byte_idx     : index of the byte on the line; 0 when idle
//   done         : one-cycle pulse after the final stop bit
module uart_frame_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] byte_in0,
    input  logic [7:0] byte_in1,
    input  logic [7:0] byte_in2,
    output logic       tx,
    output logic       busy,
    output logic [1:0] byte_idx,
    output logic       done
);

    localparam logic [1:0] FIRST_IDX = 2'(FRAME_BYTES - 1);

    logic       busy_q, busy_d;
    logic [1:0] idx_q, idx_d;
    logic       done_q, done_d;
    logic [7:0] byte1_q, byte1_d;
    logic [7:0] byte0_q, byte0_d;
    logic       accept, advance, finish;
    logic       tx_valid, tx_ready;
    logic [7:0] tx_data;

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clk  (clk),
        .rst_n(rst_n),
        .valid(tx_valid),
        .data (tx_data),
        .ready(tx_ready),
        .tx   (tx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            byte1_q <= '0;
            byte0_q <= '0;
        end else begin
            busy_q  <= busy_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            byte1_q <= byte1_d;
            byte0_q <= byte0_d;
        end
    end

    // Byte 2 goes straight from the input into the serializer on the accept
    // edge, so only bytes 1 and 0 are held here. While busy, tx_ready is high
    // only in the last cycle of a stop bit, which is where the next byte is
    // handed over.
    always_comb begin
        accept  = start && !busy_q;
        advance = busy_q && tx_ready && (idx_q != 2'd0);
        finish  = busy_q && tx_ready && (idx_q == 2'd0);

        tx_valid = accept || advance;
        tx_data  = byte_in2;
        if (!accept) begin
            tx_data = (idx_q == 2'd2) ? byte1_q : byte0_q;
        end

        busy_d  = busy_q;
        idx_d   = idx_q;
        done_d  = finish;
        byte1_d = byte1_q;
        byte0_d = byte0_q;

        if (accept) begin
            busy_d  = 1'b1;
            idx_d   = FIRST_IDX;
            byte1_d = byte_in1;
            byte0_d = byte_in0;
        end else if (advance) begin
            idx_d = idx_q - 2'd1;
        end else if (finish) begin
            busy_d = 1'b0;
            idx_d  = '0;
        end
    end

    assign busy     = busy_q;
    assign byte_idx = idx_q;
    assign done     = done_q;

endmodule

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
- Transmit-side counterpart of the UART receive path's 3-byte shift register.
- Accepts a 3-byte frame in parallel and serializes it onto the UART TX line as three back-to-back 8N1 characters.
- Byte ordering is chosen so that the receiving 3-byte shift register ends with each byte at the same index it had here. Byte 2 is sent first, then byte 1, then byte 0.
- Sits between the control logic that loads the frame and the tx pin.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 115200, line bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD (integer division; 434 at the defaults), clock cycles per serial bit. Must be at least 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to send a frame; honoured only when busy=0.
- byte_in0  in  8  frame byte 0, sent last.
- byte_in1  in  8  frame byte 1, sent second.
- byte_in2  in  8  frame byte 2, sent first.
- tx  out  1  serial line; idle high.
- busy  out  1  high while a frame is in flight.
- byte_idx  out  2  index (2, 1 or 0) of the byte currently on the line; 0 when idle.
- done  out  1  one-cycle pulse when the final stop bit completes.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Outputs: tx=1, busy=0, byte_idx=0, done=0.
  - State: FSM goes to IDLE; bit and baud counters clear to 0; latched bytes clear to 0.
  - Reset mid-frame aborts immediately; tx returns high on that same edge.
- Acceptance:
  - On an edge with start=1 and busy=0, all three byte_in values are latched.
  - Inputs may change freely after the acceptance edge.
  - start while busy=1 is ignored; no queuing.
- Latency:
  - Let E0 be the accept edge. From E0: busy=1, byte_idx=2, tx=0 (start bit of byte 2).
  - Each bit holds for exactly CLKS_PER_BIT cycles.
  - Characters go back-to-back with no idle gap: the stop bit of byte 2 is followed directly by the start bit of byte 1.
  - Full frame length is 30*CLKS_PER_BIT cycles.
  - At edge E0+30*CLKS_PER_BIT: busy=0, byte_idx=0, tx=1, done=1 for one cycle.
- Character format:
  - One start bit (0), then 8 data bits LSB first, then one stop bit (1).
  - No parity.
- FSM states (one baud period per bit state):
  - IDLE: go to START on an accepted start.
  - START: go to DATA after one baud period.
  - DATA: each bit lasts one baud period; go to STOP after bit 7.
  - STOP: after one baud period, if byte_idx>0 then decrement byte_idx and go to START; if byte_idx=0 go to IDLE and pulse done.
- Counters:
  - baud_cnt is $clog2(CLKS_PER_BIT) bits wide, counts 0..CLKS_PER_BIT-1, and wraps to 0 on each bit boundary.
  - bit_cnt is 3 bits and counts 0..7 in DATA.
- done / start on the same edge:
  - done is asserted during the cycle in which busy=0.
  - A start sampled at the next edge is accepted, giving back-to-back frames with one idle-high cycle between them.
- Glitch-free output: tx is driven directly from a flop.

Decomposition:
- Package uart_pkg:
  - State enum tx_state_t {IDLE, START, DATA, STOP}.
  - Constant function calc_clks_per_bit(clk_freq, baud).
  - localparam UART_DATA_BITS=8.
  - Constant FRAME_BYTES=3, shared with the receive-side shift register.
- Sub-module uart_tx_byte:
  - Single-character 8N1 serializer with a valid/ready handshake; owns baud_cnt, bit_cnt and the tx flop.
  - uart_frame_tx holds the latched bytes, the byte_idx sequencer, busy and done, and issues the next byte on the cycle ready returns.
  - That handoff must preserve the zero-gap back-to-back timing specified above.

Test Plan:
- Bench parameters: CLK_FREQ=1000, BAUD=100, so CLKS_PER_BIT=10.
- Basic frame:
  - Stimulus: reset, then start with byte_in2=0xA5, byte_in1=0x3C, byte_in0=0x01.
  - Check tx over 300 cycles: bits 0,1,0,1,0,0,1,0,1,1, then 0,0,0,1,1,1,1,0,0,1, then 0,1,0,0,0,0,0,0,0,1, each held 10 cycles.
  - Check done at cycle 300 and busy high for cycles 0..299.
- Loopback: sample tx mid-bit, feed the decoded bytes into the 3-byte shift register model → probe2=0xA5, probe1=0x3C, probe0=0x01.
- Busy ignore: a start with different data at cycle 50 → transmitted bits unchanged and done fires exactly once, at cycle 300.
- Back-to-back: a start on the cycle after done → the new start bit begins at cycle 301, with tx=1 for exactly one cycle between frames.
- Reset mid-frame: rst_n=0 at cycle 125 → tx=1, busy=0, done=0 from that edge; the next start sends a clean full frame.
- Idle / input change: byte_in changed right after the accept edge → the latched values are sent; no start → tx stays 1 and byte_idx stays 0 for 1000 cycles.
